// File: rtl/alu_queue_ctrl.sv
// ALU issue-queue controller. It drives the per-entry write strobes, tracks occupancy,
// collapses the queue when an entry issues and runs a registered valid/ready issue handshake.
module alu_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic [TAG_W-1:0]         dispatch_op1_tag,
    input  logic                     dispatch_op1_valid,
    input  logic [TAG_W-1:0]         dispatch_op2_tag,
    input  logic                     dispatch_op2_valid,
    input  logic [DEPTH-1:0]         entry_valid,
    input  logic [DEPTH-1:0]         entry_ready,
    input  logic [DEPTH*TAG_W-1:0]   entry_op1_tag,
    input  logic [DEPTH-1:0]         entry_op1_valid,
    input  logic [DEPTH*TAG_W-1:0]   entry_op2_tag,
    input  logic [DEPTH-1:0]         entry_op2_valid,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    output logic [DEPTH-1:0]         ent_we,
    output logic [DEPTH-1:0]         ent_updt_cmn,
    output logic [DEPTH-1:0]         ent_updt_op1,
    output logic [DEPTH-1:0]         ent_updt_op1_cdb,
    output logic [DEPTH-1:0]         ent_updt_op2,
    output logic [DEPTH-1:0]         ent_updt_op2_cdb,
    output logic [2*DEPTH-1:0]       ent_src_sel,
    output logic                     ent_flush,
    output logic                     issue_valid,
    output logic [IDX_W-1:0]         issue_idx,
    input  logic                     issue_ready,
    output logic                     queue_full,
    output logic [CNT_W-1:0]         queue_count
);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_issue_valid;
    logic [IDX_W-1:0]   r_issue_idx;

    logic               w_full;
    logic               w_hs;
    logic               w_acc;
    logic [CNT_W-1:0]   w_tail;
    logic [DEPTH-1:0]   w_shift;
    logic [DEPTH-1:0]   w_clear;
    logic [DEPTH-1:0]   w_load;
    logic [DEPTH-1:0]   w_wake_op1;
    logic [DEPTH-1:0]   w_wake_op2;
    logic               w_dis_cdb_op1;
    logic               w_dis_cdb_op2;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;

    // Operand state of entry i+1 seen at index i; the top slot reads as valid so it never captures.
    logic [DEPTH-1:0]       w_nxt_op1_valid;
    logic [DEPTH-1:0]       w_nxt_op2_valid;
    logic [DEPTH*TAG_W-1:0] w_nxt_op1_tag;
    logic [DEPTH*TAG_W-1:0] w_nxt_op2_tag;

    assign w_nxt_op1_valid = {1'b1, entry_op1_valid[DEPTH-1:1]};
    assign w_nxt_op2_valid = {1'b1, entry_op2_valid[DEPTH-1:1]};
    assign w_nxt_op1_tag   = {{TAG_W{1'b0}}, entry_op1_tag[DEPTH*TAG_W-1:TAG_W]};
    assign w_nxt_op2_tag   = {{TAG_W{1'b0}}, entry_op2_tag[DEPTH*TAG_W-1:TAG_W]};

    assign w_full         = (r_count == CNT_W'(DEPTH));
    assign w_hs           = r_issue_valid & issue_ready & ~flush;
    assign w_acc          = dispatch_valid & ~w_full & ~flush;
    assign w_tail         = r_count - CNT_W'(w_hs);
    assign w_dis_cdb_op1  = cdb_valid & ~dispatch_op1_valid & (dispatch_op1_tag == cdb_tag);
    assign w_dis_cdb_op2  = cdb_valid & ~dispatch_op2_valid & (dispatch_op2_tag == cdb_tag);

    assign dispatch_ready = ~w_full;
    assign queue_full     = w_full;
    assign queue_count    = r_count;
    assign issue_valid    = r_issue_valid;
    assign issue_idx      = r_issue_idx;
    assign ent_flush      = flush;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        w_shift    = '0;
        w_clear    = '0;
        w_load     = '0;
        w_wake_op1 = '0;
        w_wake_op2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_shift[i] = w_hs && (CNT_W'(i) >= CNT_W'(r_issue_idx)) && (CNT_W'(i) + 1'b1 < r_count);
            w_clear[i] = w_hs && !w_acc && (CNT_W'(i) + 1'b1 == r_count);
            w_load[i]  = w_acc && (CNT_W'(i) == w_tail);
            w_wake_op1[i] = entry_valid[i] & ~entry_op1_valid[i] & cdb_valid &
                            (entry_op1_tag[i*TAG_W +: TAG_W] == cdb_tag);
            w_wake_op2[i] = entry_valid[i] & ~entry_op2_valid[i] & cdb_valid &
                            (entry_op2_tag[i*TAG_W +: TAG_W] == cdb_tag);
        end
    end

    always_comb begin
        ent_we           = '0;
        ent_updt_cmn     = '0;
        ent_updt_op1     = '0;
        ent_updt_op1_cdb = '0;
        ent_updt_op2     = '0;
        ent_updt_op2_cdb = '0;
        ent_src_sel      = '0;
        if (!rst && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    ent_src_sel[2*i +: 2] = 2'b10;
                    ent_we[i]             = 1'b1;
                    ent_updt_cmn[i]       = 1'b1;
                    ent_updt_op1[i]       = 1'b1;
                    ent_updt_op2[i]       = 1'b1;
                    ent_updt_op1_cdb[i]   = w_dis_cdb_op1;
                    ent_updt_op2_cdb[i]   = w_dis_cdb_op2;
                end else if (w_shift[i]) begin
                    ent_src_sel[2*i +: 2] = 2'b01;
                    ent_we[i]             = 1'b1;
                    ent_updt_cmn[i]       = 1'b1;
                    ent_updt_op1[i]       = 1'b1;
                    ent_updt_op2[i]       = 1'b1;
                    ent_updt_op1_cdb[i]   = cdb_valid & ~w_nxt_op1_valid[i] &
                                            (w_nxt_op1_tag[i*TAG_W +: TAG_W] == cdb_tag);
                    ent_updt_op2_cdb[i]   = cdb_valid & ~w_nxt_op2_valid[i] &
                                            (w_nxt_op2_tag[i*TAG_W +: TAG_W] == cdb_tag);
                end else if (w_clear[i]) begin
                    // Vacated tail slot loads the empty common block from above.
                    ent_src_sel[2*i +: 2] = 2'b01;
                    ent_we[i]             = 1'b1;
                    ent_updt_cmn[i]       = 1'b1;
                end else begin
                    ent_we[i]             = w_wake_op1[i] | w_wake_op2[i];
                    ent_updt_op1[i]       = w_wake_op1[i];
                    ent_updt_op1_cdb[i]   = w_wake_op1[i];
                    ent_updt_op2[i]       = w_wake_op2[i];
                    ent_updt_op2_cdb[i]   = w_wake_op2[i];
                end
            end
        end
    end

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_valid[i] && entry_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_idx   <= '0;
        end else if (flush) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_idx   <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_acc) - CNT_W'(w_hs);
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_issue_idx   <= w_sel_idx;
                        r_issue_valid <= 1'b1;
                        r_state       <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // Index is held until accepted; the bubble after hs lets the queue settle.
                    if (w_hs) begin
                        r_issue_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_issue_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_queue_ctrl.sv
// Directed bench for alu_queue_ctrl: entry state is driven by hand and expected
// strobes are queued per step, then drained against the DUT outputs.
module tb_alu_queue_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   dispatch_valid;
    logic                   dispatch_ready;
    logic [TAG_W-1:0]       dispatch_op1_tag;
    logic                   dispatch_op1_valid;
    logic [TAG_W-1:0]       dispatch_op2_tag;
    logic                   dispatch_op2_valid;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH-1:0]       entry_ready;
    logic [DEPTH*TAG_W-1:0] entry_op1_tag;
    logic [DEPTH-1:0]       entry_op1_valid;
    logic [DEPTH*TAG_W-1:0] entry_op2_tag;
    logic [DEPTH-1:0]       entry_op2_valid;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DEPTH-1:0]       ent_we;
    logic [DEPTH-1:0]       ent_updt_cmn;
    logic [DEPTH-1:0]       ent_updt_op1;
    logic [DEPTH-1:0]       ent_updt_op1_cdb;
    logic [DEPTH-1:0]       ent_updt_op2;
    logic [DEPTH-1:0]       ent_updt_op2_cdb;
    logic [2*DEPTH-1:0]     ent_src_sel;
    logic                   ent_flush;
    logic                   issue_valid;
    logic [1:0]             issue_idx;
    logic                   issue_ready;
    logic                   queue_full;
    logic [2:0]             queue_count;

    alu_queue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op1_valid(dispatch_op1_valid),
        .dispatch_op2_tag(dispatch_op2_tag), .dispatch_op2_valid(dispatch_op2_valid),
        .entry_valid(entry_valid), .entry_ready(entry_ready),
        .entry_op1_tag(entry_op1_tag), .entry_op1_valid(entry_op1_valid),
        .entry_op2_tag(entry_op2_tag), .entry_op2_valid(entry_op2_valid),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .ent_we(ent_we), .ent_updt_cmn(ent_updt_cmn),
        .ent_updt_op1(ent_updt_op1), .ent_updt_op1_cdb(ent_updt_op1_cdb),
        .ent_updt_op2(ent_updt_op2), .ent_updt_op2_cdb(ent_updt_op2_cdb),
        .ent_src_sel(ent_src_sel), .ent_flush(ent_flush),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .queue_full(queue_full), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef enum {
        S_COUNT, S_FULL, S_DRDY, S_IVALID, S_IIDX, S_WE, S_CMN,
        S_OP1, S_OP1C, S_OP2, S_OP2C, S_SRC, S_FLUSH
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            S_COUNT:  return 32'(queue_count);
            S_FULL:   return 32'(queue_full);
            S_DRDY:   return 32'(dispatch_ready);
            S_IVALID: return 32'(issue_valid);
            S_IIDX:   return 32'(issue_idx);
            S_WE:     return 32'(ent_we);
            S_CMN:    return 32'(ent_updt_cmn);
            S_OP1:    return 32'(ent_updt_op1);
            S_OP1C:   return 32'(ent_updt_op1_cdb);
            S_OP2:    return 32'(ent_updt_op2);
            S_OP2C:   return 32'(ent_updt_op2_cdb);
            S_SRC:    return 32'(ent_src_sel);
            S_FLUSH:  return 32'(ent_flush);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input sig_e s, input logic [31:0] v);
        q.push_back('{sig: s, val: v});
    endtask

    task automatic check(input string step);
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.sig);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", step, e.sig.name(), obs, e.val);
            end
        end
    endtask

    task automatic quiet();
        flush = 0; dispatch_valid = 0; issue_ready = 0; cdb_valid = 0; cdb_tag = '0;
        dispatch_op1_tag = '0; dispatch_op1_valid = 1; dispatch_op2_tag = '0; dispatch_op2_valid = 1;
        entry_valid = '0; entry_ready = '0; entry_op1_valid = '1; entry_op2_valid = '1;
        entry_op1_tag = '0; entry_op2_tag = '0;
    endtask

    task automatic set_entries(input logic [3:0] v, input logic [3:0] r,
                               input logic [3:0] o1v, input logic [3:0] o2v);
        entry_valid = v; entry_ready = r; entry_op1_valid = o1v; entry_op2_valid = o2v;
    endtask

    task automatic dispatch(input logic [5:0] t2, input logic v2);
        dispatch_valid = 1; dispatch_op1_tag = 6'h01; dispatch_op1_valid = 1;
        dispatch_op2_tag = t2; dispatch_op2_valid = v2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        rst = 1;
        // Reset: wakeup/dispatch conditions present but every strobe must stay low.
        dispatch(6'h00, 1'b1);
        entry_valid = 4'b0001; entry_op1_valid = 4'b1110; cdb_valid = 1;
        @(negedge clk);
        push(S_COUNT, 0); push(S_IVALID, 0); push(S_IIDX, 0); push(S_WE, 0);
        push(S_OP1, 0); push(S_SRC, 0); push(S_DRDY, 1); push(S_FULL, 0);
        #1 check("reset");
        rst = 0; quiet();

        // 1: fill the queue with four ready instructions.
        @(negedge clk); dispatch(6'h00, 1'b1);
        push(S_WE, 4'b0001); push(S_CMN, 4'b0001); push(S_OP1, 4'b0001); push(S_OP2, 4'b0001);
        push(S_OP1C, 0); push(S_SRC, 8'h02); push(S_DRDY, 1);
        #1 check("d0");
        @(negedge clk); set_entries(4'b0001, 4'b0001, 4'hF, 4'hF);
        push(S_COUNT, 1); push(S_IVALID, 0); push(S_WE, 4'b0010); push(S_SRC, 8'h08);
        #1 check("d1");
        @(negedge clk); set_entries(4'b0011, 4'b0011, 4'hF, 4'hF);
        push(S_COUNT, 2); push(S_IVALID, 1); push(S_IIDX, 0); push(S_WE, 4'b0100); push(S_SRC, 8'h20);
        #1 check("d2");
        @(negedge clk); set_entries(4'b0111, 4'b0111, 4'hF, 4'hF);
        push(S_COUNT, 3); push(S_WE, 4'b1000); push(S_SRC, 8'h80); push(S_FULL, 0);
        #1 check("d3");
        @(negedge clk); set_entries(4'b1111, 4'b1111, 4'hF, 4'hF);
        push(S_COUNT, 4); push(S_FULL, 1); push(S_DRDY, 0); push(S_WE, 0); push(S_SRC, 0);
        #1 check("full_reject");

        // Issue idx 0 from a full queue: whole queue collapses, tail slot cleared.
        @(negedge clk); dispatch_valid = 0; issue_ready = 1;
        push(S_WE, 4'hF); push(S_CMN, 4'hF); push(S_OP1, 4'h7); push(S_OP2, 4'h7);
        push(S_SRC, 8'h55); push(S_OP1C, 0); push(S_COUNT, 4);
        #1 check("hs_full");

        // 2: bubble, refill, then entry 2 is the oldest ready one.
        @(negedge clk); issue_ready = 0; dispatch(6'h00, 1'b1);
        set_entries(4'b0111, 4'b0100, 4'hF, 4'hF);
        push(S_COUNT, 3); push(S_IVALID, 0); push(S_WE, 4'b1000); push(S_SRC, 8'h80);
        #1 check("bubble");
        @(negedge clk); dispatch_valid = 0; issue_ready = 1;
        set_entries(4'b1111, 4'b0100, 4'hF, 4'hF);
        push(S_IVALID, 1); push(S_IIDX, 2); push(S_COUNT, 4); push(S_SRC, 8'h50);
        push(S_WE, 4'b1100); push(S_CMN, 4'b1100); push(S_OP1, 4'b0100);
        #1 check("hs_idx2");

        // 3: CDB wakeup of entry 1 op1 only.
        @(negedge clk); issue_ready = 0;
        set_entries(4'b0111, 4'b0101, 4'b0101, 4'hF);
        entry_op1_tag = {DEPTH{6'h15}}; cdb_valid = 1; cdb_tag = 6'h15;
        push(S_COUNT, 3); push(S_IVALID, 0); push(S_WE, 4'b0010); push(S_OP1, 4'b0010);
        push(S_OP1C, 4'b0010); push(S_OP2, 0); push(S_OP2C, 0); push(S_SRC, 0); push(S_CMN, 0);
        #1 check("wakeup");

        // 4: hs idx 0 + dispatch + CDB capture by shifted and dispatched copies.
        @(negedge clk); issue_ready = 1; dispatch(6'h09, 1'b0);
        set_entries(4'b0111, 4'b0011, 4'hF, 4'b1011);
        entry_op1_tag = '0; entry_op2_tag = {DEPTH{6'h09}}; cdb_valid = 1; cdb_tag = 6'h09;
        push(S_IVALID, 1); push(S_IIDX, 0); push(S_COUNT, 3); push(S_SRC, 8'h25);
        push(S_WE, 4'b0111); push(S_CMN, 4'b0111); push(S_OP2, 4'b0111);
        push(S_OP2C, 4'b0110); push(S_OP1C, 0);
        #1 check("hs_dispatch_cdb");

        @(negedge clk); quiet(); set_entries(4'b0111, 4'b0010, 4'hF, 4'hF);
        push(S_COUNT, 3); push(S_IVALID, 0);
        #1 check("bubble2");

        // 5: ALU stalls; offer must hold even though entry 0 becomes ready.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); set_entries(4'b0111, 4'b0011, 4'hF, 4'hF);
            push(S_IVALID, 1); push(S_IIDX, 1); push(S_WE, 0); push(S_COUNT, 3);
            #1 check($sformatf("stall%0d", c));
        end

        // 6: flush in OFFER drops dispatch, handshake and wakeup.
        @(negedge clk); flush = 1; issue_ready = 1; dispatch(6'h00, 1'b1);
        entry_op1_valid = 4'b0101; entry_op1_tag = {DEPTH{6'h15}}; cdb_valid = 1; cdb_tag = 6'h15;
        push(S_FLUSH, 1); push(S_WE, 0); push(S_OP1C, 0); push(S_SRC, 0); push(S_COUNT, 3);
        #1 check("flush_cycle");
        @(negedge clk); quiet(); dispatch(6'h00, 1'b1);
        push(S_COUNT, 0); push(S_IVALID, 0); push(S_IIDX, 0); push(S_FLUSH, 0); push(S_WE, 4'b0001);
        #1 check("post_flush");
        @(negedge clk); set_entries(4'b0001, 4'b0001, 4'hF, 4'hF);
        push(S_COUNT, 1); push(S_WE, 4'b0010);
        #1 check("refill");
        @(negedge clk); dispatch_valid = 0; set_entries(4'b0011, 4'b0011, 4'hF, 4'hF);
        push(S_COUNT, 2); push(S_IVALID, 1); push(S_IIDX, 0);
        #1 check("pre_rst");

        // Asynchronous reset between clock edges.
        #1 rst = 1; dispatch(6'h00, 1'b1);
        push(S_COUNT, 0); push(S_IVALID, 0); push(S_WE, 0); push(S_SRC, 0);
        #1 check("async_rst");
        @(negedge clk); rst = 0; set_entries(4'b0000, 4'b0000, 4'hF, 4'hF);
        push(S_COUNT, 0); push(S_WE, 4'b0001); push(S_DRDY, 1);
        #1 check("after_rst");
        @(negedge clk); quiet();
        push(S_COUNT, 1); push(S_IVALID, 0);
        #1 check("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
